int_ctrl: RTL and testbench

//  Interrupt controller that sits between the interrupt sources and the PicoBlaze core.

---
 rtl/int_ctrl.sv | 145 ++++++++++++++
 tb/tb_int_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller for the PicoBlaze port bus: mask/pending/ID
// registers, one interrupt/interrupt_ack handshake, and an EOI-driven source ack.
module int_ctrl #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] ADDR_MASK = 8'h10,
  parameter logic [7:0] ADDR_PEND = 8'h11,
  parameter logic [7:0] ADDR_ID   = 8'h12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       address,
  input  logic [7:0]       value_in,
  input  logic             wen,
  input  logic             ren,
  output logic [7:0]       port_out,
  input  logic [N_SRC-1:0] irq_in,
  output logic [N_SRC-1:0] irq_ack,
  output logic             interrupt,
  input  logic             interrupt_ack,
  output logic [1:0]       dbg_state
);

  // Handshake: interrupt rises when a source is committed and stays high until the
  // CPU pulses interrupt_ack; an EOI write then pulses irq_ack for that source once.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] irq_ack_q, irq_ack_d;
  logic [2:0]       cur_id_q, cur_id_d;
  logic [1:0]       hold_cnt_q, hold_cnt_d;
  logic             interrupt_q, interrupt_d;
  logic [7:0]       port_out_q, port_out_d;

  logic [N_SRC-1:0] act;
  logic [2:0]       first_id;
  logic [N_SRC-1:0] ack_vec;
  logic [7:0]       mask_rd, pend_rd;
  logic             eoi;
  logic             unused_value;

  assign act          = pend_q & mask_q;
  assign eoi          = wen && (address == ADDR_ID);
  assign unused_value = ^value_in;

  // Descending scan so the lowest set index wins.
  always_comb begin
    first_id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) first_id = i[2:0];
    end
  end

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cur_id_q == i[2:0]) ack_vec[i] = 1'b1;
    end
  end

  always_comb begin
    mask_rd = '0;
    pend_rd = '0;
    mask_rd[N_SRC-1:0] = mask_q;
    pend_rd[N_SRC-1:0] = pend_q;
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    pend_d      = irq_in;
    irq_ack_d   = '0;
    cur_id_d    = cur_id_q;
    hold_cnt_d  = hold_cnt_q;
    interrupt_d = interrupt_q;
    port_out_d  = port_out_q;

    if (wen && (address == ADDR_MASK)) mask_d = value_in[N_SRC-1:0];

    case (state_q)
      S_IDLE: begin
        if (|act) begin
          cur_id_d    = first_id;
          interrupt_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (interrupt_ack) begin
          interrupt_d = 1'b0;
          state_d     = S_SVC;
        end
      end
      S_SVC: begin
        if (eoi && !interrupt_ack) begin
          irq_ack_d  = ack_vec;
          hold_cnt_d = 2'd0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Let the source drop its line and pend resample before re-arbitrating.
        if (hold_cnt_q == 2'd2) state_d = S_IDLE;
        else hold_cnt_d = hold_cnt_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (ren) begin
      if (address == ADDR_MASK) port_out_d = mask_rd;
      else if (address == ADDR_PEND) port_out_d = pend_rd;
      else if (address == ADDR_ID)
        port_out_d = (state_q == S_SVC) ? {1'b1, 4'b0000, cur_id_q} : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      pend_q      <= '0;
      irq_ack_q   <= '0;
      cur_id_q    <= 3'd0;
      hold_cnt_q  <= 2'd0;
      interrupt_q <= 1'b0;
      port_out_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      irq_ack_q   <= irq_ack_d;
      cur_id_q    <= cur_id_d;
      hold_cnt_q  <= hold_cnt_d;
      interrupt_q <= interrupt_d;
      port_out_q  <= port_out_d;
    end
  end

  assign port_out  = port_out_q;
  assign irq_ack   = irq_ack_q;
  assign interrupt = interrupt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus randomized mask/request sets checked
// against a service-order model (ascending index of requested & enabled sources).
module tb_int_ctrl;
  localparam int N = 4;
  localparam logic [7:0] A_MASK = 8'h10, A_PEND = 8'h11, A_ID = 8'h12;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_SVC = 2'd2, ST_HOLD = 2'd3;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] address = 8'h00, value_in = 8'h00;
  logic wen = 1'b0, ren = 1'b0, interrupt_ack = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic [7:0] port_out;
  logic [N-1:0] irq_ack;
  logic interrupt;
  logic [1:0] dbg_state;

  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];

  int_ctrl #(.N_SRC(N), .ADDR_MASK(A_MASK), .ADDR_PEND(A_PEND), .ADDR_ID(A_ID)) dut (
    .clk(clk), .rst(rst), .address(address), .value_in(value_in), .wen(wen), .ren(ren),
    .port_out(port_out), .irq_in(irq_in), .irq_ack(irq_ack), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); address = a; value_in = d; wen = 1'b1;
    @(negedge clk); wen = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk); address = a; ren = 1'b1;
    @(negedge clk); ren = 1'b0; d = port_out;
  endtask

  task automatic pulse_ack();
    @(negedge clk); interrupt_ack = 1'b1;
    @(negedge clk); interrupt_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_int(input string name, input int budget);
    int k;
    k = 0;
    while (interrupt !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL %s: interrupt timeout, got %b want 1", name, interrupt);
    end
  endtask

  // EOI write; checks the one-cycle ack pulse, drops the acked line, waits for IDLE.
  task automatic eoi_service(input string name, input logic [N-1:0] exp_ack);
    @(negedge clk); address = A_ID; value_in = $urandom_range(0, 255); wen = 1'b1;
    @(negedge clk); wen = 1'b0;
    checks++;
    if (irq_ack !== exp_ack) begin
      errors++; $display("FAIL %s ack_pulse: got %b want %b", name, irq_ack, exp_ack);
    end
    irq_in = irq_in & ~exp_ack;
    @(negedge clk);
    checks++;
    if (irq_ack !== '0) begin
      errors++; $display("FAIL %s ack_width: got %b want 0", name, irq_ack);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_HOLD) begin
      errors++; $display("FAIL %s hold: state got %0d want %0d", name, dbg_state, ST_HOLD);
    end
    @(negedge clk);
    checks++;
    if (dbg_state === ST_HOLD) begin
      errors++; $display("FAIL %s hold_exit: state still %0d after 3 cycles", name, dbg_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; idle_cycles(3); rst = 1'b0;
    checks++;
    if (interrupt !== 1'b0 || irq_ack !== '0 || port_out !== 8'h00) begin
      errors++; $display("FAIL reset_out: int=%b ack=%b port=%h want 0/0/00", interrupt, irq_ack, port_out);
    end
    cpu_read(A_MASK, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h want 00", d); end
    cpu_read(A_PEND, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h want 00", d); end
    cpu_read(A_ID, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_id: got %h want 00", d); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    cpu_write(A_MASK, 8'h0F);
    irq_in = 4'b0100;
    @(negedge clk); checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL single_lat1: got %b want 0", interrupt); end
    @(negedge clk); checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL single_lat2: got %b want 1", interrupt); end
    cpu_read(A_ID, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL single_id_req: got %h want 00", d); end
    pulse_ack(); checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL single_deassert: got %b want 0", interrupt); end
    cpu_read(A_ID, d); checks++;
    if (d !== 8'h82) begin errors++; $display("FAIL single_id: got %h want 82", d); end
    eoi_service("single", 4'b0100);
  endtask

  task automatic test_priority();
    logic [7:0] d;
    cpu_write(A_MASK, 8'h0F);
    irq_in = 4'b1010;
    wait_int("prio_first", 10);
    pulse_ack();
    cpu_read(A_ID, d); checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL prio_id1: got %h want 81", d); end
    eoi_service("prio1", 4'b0010);
    wait_int("prio_second", 10);
    pulse_ack();
    cpu_read(A_ID, d); checks++;
    if (d !== 8'h83) begin errors++; $display("FAIL prio_id3: got %h want 83", d); end
    eoi_service("prio3", 4'b1000);
  endtask

  task automatic test_mask();
    logic [7:0] d;
    cpu_write(A_MASK, 8'h00);
    irq_in = 4'b0001;
    idle_cycles(5); checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_block: got %b want 0", interrupt); end
    cpu_read(A_PEND, d); checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL mask_pend: got %h want 01", d); end
    cpu_write(A_MASK, 8'hF1);
    cpu_read(A_MASK, d); checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL mask_upper: got %h want 01", d); end
    wait_int("mask_enable", 10);
    pulse_ack();
    eoi_service("mask", 4'b0001);
  endtask

  task automatic check_after_rst(input string name);
    logic [7:0] d;
    checks++;
    if (interrupt !== 1'b0 || dbg_state !== ST_IDLE || irq_ack !== '0) begin
      errors++; $display("FAIL %s: int=%b state=%0d ack=%b want 0/0/0", name, interrupt, dbg_state, irq_ack);
    end
    cpu_read(A_MASK, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL %s_mask: got %h want 00", name, d); end
  endtask

  task automatic test_reset_mid();
    cpu_write(A_MASK, 8'h0F);
    irq_in = 4'b0010;
    wait_int("rst_req_setup", 10);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_after_rst("rst_in_req");
    cpu_write(A_MASK, 8'h0F);
    wait_int("rst_svc_setup", 10);
    pulse_ack();
    // EOI coincides with reset: no ack pulse may escape.
    @(negedge clk); rst = 1'b1; address = A_ID; wen = 1'b1;
    @(negedge clk); rst = 1'b0; wen = 1'b0;
    checks++;
    if (irq_ack !== '0) begin errors++; $display("FAIL rst_svc_ack: got %b want 0", irq_ack); end
    @(negedge clk); checks++;
    if (irq_ack !== '0) begin errors++; $display("FAIL rst_svc_ack2: got %b want 0", irq_ack); end
    check_after_rst("rst_in_svc");
    irq_in = '0;
    idle_cycles(3);
  endtask

  task automatic test_ignored();
    cpu_write(A_ID, 8'h55);
    checks++;
    if (irq_ack !== '0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL idle_eoi: ack=%b state=%0d want 0/0", irq_ack, dbg_state);
    end
    pulse_ack(); checks++;
    if (interrupt !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL idle_iack: int=%b state=%0d want 0/0", interrupt, dbg_state);
    end
    // In SVC, EOI together with interrupt_ack is dropped; a clean EOI afterwards works.
    cpu_write(A_MASK, 8'h0F);
    irq_in = 4'b0001;
    wait_int("eoi_ack_setup", 10);
    pulse_ack();
    @(negedge clk); address = A_ID; wen = 1'b1; interrupt_ack = 1'b1;
    @(negedge clk); wen = 1'b0; interrupt_ack = 1'b0;
    checks++;
    if (irq_ack !== '0 || dbg_state !== ST_SVC) begin
      errors++; $display("FAIL eoi_with_iack: ack=%b state=%0d want 0/%0d", irq_ack, dbg_state, ST_SVC);
    end
    eoi_service("eoi_after", 4'b0001);
  endtask

  task automatic test_random();
    logic [7:0] d, exp_id;
    logic [N-1:0] m, r;
    for (int it = 0; it < 12; it++) begin
      m = N'($urandom_range(0, 15));
      r = N'($urandom_range(1, 15));
      cpu_write(A_MASK, {4'($urandom_range(0, 15)), m});
      irq_in = r;
      for (int b = 0; b < N; b++)
        if (r[b] && m[b]) exp_q.push_back(8'h80 | 8'(b));
      while (exp_q.size() > 0) begin
        exp_id = exp_q.pop_front();
        wait_int("rand_int", 12);
        pulse_ack();
        cpu_read(A_ID, d); checks++;
        if (d !== exp_id) begin
          errors++; $display("FAIL rand_id it=%0d mask=%b irq=%b: got %h want %h", it, m, r, d, exp_id);
        end
        eoi_service("rand", N'(1) << exp_id[2:0]);
      end
      idle_cycles(4); checks++;
      if (interrupt !== 1'b0) begin
        errors++; $display("FAIL rand_quiet it=%0d: interrupt got %b want 0", it, interrupt);
      end
      cpu_read(A_PEND, d); checks++;
      if (d !== {4'b0000, r & ~m}) begin
        errors++; $display("FAIL rand_pend it=%0d: got %h want %h", it, d, {4'b0000, r & ~m});
      end
      irq_in = '0;
      idle_cycles(2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
